// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared encodings for the ALU decoder and iterative multiply/divide unit
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND    = 4'b0000,
    ALU_OR     = 4'b0001,
    ALU_ADD    = 4'b0010,
    ALU_XOR    = 4'b0011,
    ALU_SLL    = 4'b0100,
    ALU_SRL    = 4'b0101,
    ALU_SUB    = 4'b0110,
    ALU_SLT    = 4'b0111,
    ALU_BRANCH = 4'b1000,
    ALU_SRA    = 4'b1001,
    ALU_SLTU   = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_ARITH  = 2'b10,
    ALUOP_JUMP   = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_CALC = 2'b01,
    MDU_DONE = 2'b10
  } mdu_state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

endpackage

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - one-bit-per-cycle shift-add multiplier and restoring divider
// Operands are latched as magnitudes at start; the sign is reapplied on the final step.
module mdu_iterative
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output mdu_state_e       state_o,
  output logic [WIDTH-1:0] result_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2:0]         f3_q, f3_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     mul_sum, div_upper;
  logic [WIDTH-1:0]   div_sub, quot, rem, calc_res, a_mag, b_mag, special_res;
  logic [2*WIDTH-1:0] mul_nxt, div_nxt, step_nxt, prod_fix;
  logic               div_ge, signed_a, signed_b, a_neg, b_neg, div_zero, div_ovf;

  // Datapath step: the accumulator upper half is the partial product or remainder.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt   = {mul_sum, acc_q[WIDTH-1:1]};
    div_upper = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = div_upper >= {1'b0, opnd_q};
    div_sub   = div_upper[WIDTH-1:0] - opnd_q;
    div_nxt   = {(div_ge ? div_sub : div_upper[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
    step_nxt  = f3_q[2] ? div_nxt : mul_nxt;
    prod_fix  = neg_res_q ? -step_nxt : step_nxt;
    quot      = neg_res_q ? -step_nxt[WIDTH-1:0] : step_nxt[WIDTH-1:0];
    rem       = neg_rem_q ? -step_nxt[2*WIDTH-1:WIDTH] : step_nxt[2*WIDTH-1:WIDTH];
    case (f3_q)
      F3_MUL:                      calc_res = prod_fix[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: calc_res = prod_fix[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:             calc_res = quot;
      default:                     calc_res = rem;
    endcase
  end

  always_comb begin
    signed_a    = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                  (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
    signed_b    = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    a_neg       = signed_a && src_a_i[WIDTH-1];
    b_neg       = signed_b && src_b_i[WIDTH-1];
    a_mag       = a_neg ? -src_a_i : src_a_i;
    b_mag       = b_neg ? -src_b_i : src_b_i;
    div_zero    = funct3_i[2] && (src_b_i == '0);
    div_ovf     = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                  (src_a_i == MOST_NEG) && (src_b_i == '1);
    if (funct3_i[1]) special_res = div_zero ? src_a_i : '0;
    else             special_res = div_zero ? '1 : MOST_NEG;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    f3_d      = f3_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    done_d    = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (start_i) begin
          f3_d      = funct3_i;
          cnt_d     = '0;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (funct3_i[2]) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
          if (div_zero || div_ovf) begin
            result_d = special_res;
            done_d   = 1'b1;
            state_d  = MDU_DONE;
          end else begin
            state_d  = MDU_CALC;
          end
        end
      end
      MDU_CALC: begin
        acc_d = step_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = calc_res;
          done_d   = 1'b1;
          state_d  = MDU_DONE;
        end
      end
      MDU_DONE: state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
    // A killed operation must leave no trace on the result or done strobe.
    if (flush_i) begin
      state_d  = MDU_IDLE;
      result_d = result_q;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      f3_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      f3_q      <= f3_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign state_o  = state_q;
  assign result_o = result_q;
  assign done_o   = done_q;

endmodule

// File: rtl/alu_mdu_controller.sv
// rtl/alu_mdu_controller.sv - execute-stage ALU operation decoder with RV32M multiply/divide stall control
module alu_mdu_controller
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  input  logic             Flush,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             ImmType,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [3:0]       Operation,
  output logic             MulDivSel,
  output logic             Stall,
  output logic [WIDTH-1:0] MdResult,
  output logic             MdDone
);

  alu_op_e    op;
  mdu_state_e md_state;
  logic       m_op;

  // I-type has no funct7 field except the SRAI selector bit.
  always_comb begin
    op = ALU_ADD;
    case (aluop_e'(ALUOp))
      ALUOP_BRANCH: op = ALU_BRANCH;
      ALUOP_ARITH: begin
        case (Funct3)
          3'b000: op = (!ImmType && Funct7 == FUNCT7_ALT) ? ALU_SUB : ALU_ADD;
          3'b001: op = ALU_SLL;
          3'b010: op = ALU_SLT;
          3'b011: op = ALU_SLTU;
          3'b100: op = ALU_XOR;
          3'b101: begin
            if (ImmType)                    op = Funct7[5] ? ALU_SRA : ALU_SRL;
            else if (Funct7 == FUNCT7_ALT)  op = ALU_SRA;
            else if (Funct7 == FUNCT7_BASE) op = ALU_SRL;
            else                            op = ALU_ADD;
          end
          3'b110: op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      default: op = ALU_ADD;
    endcase
  end

  assign Operation = op;
  assign m_op      = InValid && (ALUOp == ALUOP_ARITH) && !ImmType && (Funct7 == FUNCT7_MEXT);
  assign MulDivSel = m_op;
  assign Stall     = m_op && !Flush && (md_state != MDU_DONE);

  mdu_iterative #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .clk      (clk),
    .reset    (reset),
    .start_i  (m_op && !Flush),
    .flush_i  (Flush),
    .funct3_i (Funct3),
    .src_a_i  (SrcA),
    .src_b_i  (SrcB),
    .state_o  (md_state),
    .result_o (MdResult),
    .done_o   (MdDone)
  );

endmodule

// File: tb/tb_alu_mdu_controller.sv
// tb/tb_alu_mdu_controller.sv - directed bench with result scoreboard for alu_mdu_controller
module tb_alu_mdu_controller;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, InValid, Flush, ImmType;
  logic [1:0]   ALUOp;
  logic [6:0]   Funct7;
  logic [2:0]   Funct3;
  logic [W-1:0] SrcA, SrcB, MdResult;
  logic [3:0]   Operation;
  logic         MulDivSel, Stall, MdDone;

  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  alu_mdu_controller #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .Flush(Flush), .ALUOp(ALUOp),
    .Funct7(Funct7), .Funct3(Funct3), .ImmType(ImmType), .SrcA(SrcA), .SrcB(SrcB),
    .Operation(Operation), .MulDivSel(MulDivSel), .Stall(Stall),
    .MdResult(MdResult), .MdDone(MdDone)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] as_, bs_;
    logic ovf;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'b0, a};       ub = {32'b0, b};
    as_ = a; bs_ = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(as_ / bs_);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(as_ % bs_);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Scoreboard: every MdDone must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (MdDone === 1'b1) begin
      if (exp_q.size() == 0) chk("done_without_op", {31'b0, MdDone}, 32'd0);
      else chk("md_result", MdResult, exp_q.pop_front());
    end
  end

  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    InValid = 1'b1; ALUOp = 2'b10; ImmType = 1'b0; Funct7 = 7'b0000001;
    Funct3 = f3; SrcA = a; SrcB = b;
  endtask

  task automatic run_mop(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
    int   k;
    logic stall_ok;
    drive_op(f3, a, b);
    exp_q.push_back(exp);
    k = 0;
    stall_ok = 1'b1;
    @(negedge clk);
    chk({tag, "_muldivsel"}, {31'b0, MulDivSel}, 32'd1);
    while (MdDone !== 1'b1 && k < 100) begin
      if (Stall !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, k, lat);
    chk({tag, "_stall_while_busy"}, {31'b0, stall_ok}, 32'd1);
    chk({tag, "_stall_at_done"}, {31'b0, Stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle_chk(input string tag, input logic [31:0] exp);
    InValid = 1'b0;
    @(negedge clk);
    chk({tag, "_done_single"}, {31'b0, MdDone}, 32'd0);
    chk({tag, "_result_hold"}, MdResult, exp);
    @(posedge clk); #1;
  endtask

  task automatic dec(input string tag, input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                     input logic imm, input logic [3:0] exp_op);
    InValid = 1'b1; ALUOp = aop; Funct7 = f7; Funct3 = f3; ImmType = imm;
    @(negedge clk);
    chk({tag, "_op"}, {28'b0, Operation}, {28'b0, exp_op});
    chk({tag, "_stall"}, {31'b0, Stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, b, e;
    logic [2:0]  f3;
    int          lat;
    reset = 1'b1; InValid = 1'b0; Flush = 1'b0; ImmType = 1'b0; ALUOp = 2'b00;
    Funct7 = '0; Funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    chk("reset_mddone", {31'b0, MdDone}, 32'd0);
    chk("reset_mdresult", MdResult, 32'd0);
    chk("reset_stall", {31'b0, Stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    dec("sub",   2'b10, 7'b0100000, 3'b000, 1'b0, 4'b0110);
    dec("addi",  2'b10, 7'b0100000, 3'b000, 1'b1, 4'b0010);
    dec("srai",  2'b10, 7'b0100000, 3'b101, 1'b1, 4'b1001);
    dec("sra",   2'b10, 7'b0100000, 3'b101, 1'b0, 4'b1001);
    dec("srl",   2'b10, 7'b0000000, 3'b101, 1'b0, 4'b0101);
    dec("and",   2'b10, 7'b0000000, 3'b111, 1'b0, 4'b0000);
    dec("sltu",  2'b10, 7'b0000000, 3'b011, 1'b1, 4'b1010);
    dec("load",  2'b00, 7'b0100000, 3'b010, 1'b0, 4'b0010);
    dec("branch",2'b01, 7'b0000000, 3'b001, 1'b0, 4'b1000);
    dec("lui",   2'b11, 7'b0000001, 3'b110, 1'b0, 4'b0010);
    dec("undef", 2'b10, 7'b0000010, 3'b000, 1'b0, 4'b0010);

    run_mop("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    idle_chk("mul", 32'hFFFF_FFEB);
    run_mop("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_mop("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_mop("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
    idle_chk("mulhsu", 32'hFFFF_FFFF);

    run_mop("divu_z", 3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, 1);
    run_mop("rem_z",  3'd6, 32'd100,       32'd0,         32'd100,       1);
    run_mop("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_mop("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    idle_chk("rem_ov", 32'd0);

    run_mop("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_mop("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    idle_chk("rem_neg", 32'hFFFF_FFFF);

    for (int i = 0; i < 8; i++) begin
      f3 = 3'(i);
      a = $urandom;
      b = $urandom;
      if (i >= 4) b = b >> (i * 3);
      e = ref_md(f3, a, b);
      lat = (f3[2] && (b == 0 || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
      run_mop("model", f3, a, b, e, lat);
    end
    idle_chk("model", e);

    drive_op(3'd0, 32'h0000_1234, 32'h10);
    repeat (10) begin @(posedge clk); #1; end
    Flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'b0, Stall}, 32'd0);
    @(posedge clk); #1;
    Flush = 1'b0;
    run_mop("after_flush", 3'd0, 32'h0000_1234, 32'h10, 32'h0001_2340, 33);
    idle_chk("after_flush", 32'h0001_2340);

    drive_op(3'd0, 32'd3, 32'd5);
    repeat (5) begin @(posedge clk); #1; end
    #2;
    reset = 1'b1;
    InValid = 1'b0;
    #1;
    chk("areset_mdresult", MdResult, 32'd0);
    chk("areset_mddone", {31'b0, MdDone}, 32'd0);
    chk("areset_stall", {31'b0, Stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_mop("after_reset", 3'd0, 32'd3, 32'd5, 32'd15, 33);
    idle_chk("after_reset", 32'd15);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
